// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control sequencer: walks each instruction through its datapath
// steps and stretches memory accesses on memReady, aborting after MEM_TIMEOUT waits.
module mips_multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memtoReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOperation,
    output logic [1:0] pcSrc,
    output logic       illegalOp,
    output logic       memError
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP
    } stateType;

    stateType   state;
    logic [7:0] waitCnt;
    logic       inMemState;
    logic       memTimeout;
    logic       opLegal;

    always_comb begin
        inMemState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        memTimeout = inMemState && !memReady && (waitCnt == WAIT_LIMIT);
        case (opCode)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: opLegal = 1'b1;
            default: opLegal = 1'b0;
        endcase
    end

    // The wait counter only survives a cycle spent stalling in the same memory state;
    // every other path (success, timeout, non-memory state) restarts it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            if (inMemState && !memReady && !memTimeout)
                waitCnt <= waitCnt + 8'd1;
            else
                waitCnt <= '0;

            case (state)
                FETCH:  state <= memReady ? DECODE : FETCH;
                DECODE: begin
                    case (opCode)
                        OP_RTYPE:        state <= EXEC;
                        OP_ADDI, OP_ANDI: state <= IEXEC;
                        OP_LW, OP_SW:    state <= MEMADR;
                        OP_BEQ, OP_BNE:  state <= BRANCH;
                        OP_J:            state <= JUMP;
                        default:         state <= FETCH;
                    endcase
                end
                MEMADR: state <= (opCode == OP_LW) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (memReady)
                        state <= MEMWB;
                    else if (memTimeout)
                        state <= FETCH;
                end
                MEMWR: begin
                    if (memReady || memTimeout)
                        state <= FETCH;
                end
                EXEC:   state <= ALUWB;
                IEXEC:  state <= IWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Control is decoded from the current state plus live inputs so the FETCH write
    // enables and the branch decision land in the same cycle; reset forces all quiet.
    always_comb begin
        pcWrite      = 1'b0;
        iorD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        memtoReg     = 1'b0;
        regDst       = 1'b0;
        regWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOperation = 2'b00;
        pcSrc        = 2'b00;
        illegalOp    = 1'b0;
        memError     = 1'b0;
        if (rst_n) begin
            memError = memTimeout;
            case (state)
                FETCH: begin
                    memRead = 1'b1;
                    ALUSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                DECODE: begin
                    ALUSrcB   = 2'b11;
                    illegalOp = !opLegal;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                MEMWB: begin
                    regWrite = 1'b1;
                    memtoReg = 1'b1;
                end
                MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA      = 1'b1;
                    ALUOperation = 2'b10;
                end
                ALUWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                IEXEC: begin
                    ALUSrcA      = 1'b1;
                    ALUSrcB      = 2'b10;
                    ALUOperation = (opCode == OP_ANDI) ? 2'b11 : 2'b00;
                end
                IWB: begin
                    regWrite     = 1'b1;
                    ALUOperation = (opCode == OP_ANDI) ? 2'b11 : 2'b00;
                end
                BRANCH: begin
                    ALUSrcA      = 1'b1;
                    ALUOperation = 2'b01;
                    pcSrc        = 2'b01;
                    pcWrite      = (opCode == OP_BEQ) ? zero : !zero;
                end
                JUMP: begin
                    pcSrc   = 2'b10;
                    pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle controller: directed scenarios then random traffic, all
// compared against a per-instruction step-plan model of the expected control.
module tb_mips_multicycle_controller;
    localparam int TIMEOUT = 4;

    localparam int STEP_FETCH  = 0;
    localparam int STEP_DECODE = 1;
    localparam int STEP_ADDR   = 2;
    localparam int STEP_RD     = 3;
    localparam int STEP_WBMEM  = 4;
    localparam int STEP_WR     = 5;
    localparam int STEP_EXEC   = 6;
    localparam int STEP_WBR    = 7;
    localparam int STEP_IEXEC  = 8;
    localparam int STEP_WBI    = 9;
    localparam int STEP_BR     = 10;
    localparam int STEP_JMP    = 11;

    localparam logic [5:0] LEGAL_OPS [8] = '{6'b000000, 6'b001000, 6'b001100, 6'b100011,
                                              6'b101011, 6'b000100, 6'b000101, 6'b000010};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opCode;
    logic       zero;
    logic       memReady;
    logic       pcWrite, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite;
    logic       ALUSrcA, illegalOp, memError;
    logic [1:0] ALUSrcB, ALUOperation, pcSrc;
    logic [16:0] dutVec;

    int checks = 0;
    int errors = 0;

    int         plan[$];
    int         waited = 0;
    logic [5:0] curOp = 6'd0;
    logic [5:0] nextOp = 6'd0;

    mips_multicycle_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .zero(zero), .memReady(memReady),
        .pcWrite(pcWrite), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
        .irWrite(irWrite), .memtoReg(memtoReg), .regDst(regDst), .regWrite(regWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation), .pcSrc(pcSrc),
        .illegalOp(illegalOp), .memError(memError)
    );

    always #5 clk = ~clk;

    assign dutVec = {pcWrite, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite,
                     ALUSrcA, ALUSrcB, ALUOperation, pcSrc, illegalOp, memError};

    task automatic checkOutput(input string tag, input logic [16:0] actual, input logic [16:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic isKnown(input logic [5:0] op);
        foreach (LEGAL_OPS[k])
            if (LEGAL_OPS[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [5:0] pickOp();
        int r = $urandom_range(0, 9);
        if (r < 8) return LEGAL_OPS[r];
        return 6'($urandom);
    endfunction

    function automatic int currentStep();
        return (plan.size() == 0) ? STEP_FETCH : plan[0];
    endfunction

    function automatic logic isMemStep(input int step);
        return step == STEP_FETCH || step == STEP_RD || step == STEP_WR;
    endfunction

    // Steps each instruction class walks through after its fetch completes.
    task automatic buildPlan(input logic [5:0] op);
        plan.delete();
        plan.push_back(STEP_DECODE);
        case (op)
            6'b000000: begin plan.push_back(STEP_EXEC);  plan.push_back(STEP_WBR); end
            6'b001000, 6'b001100: begin plan.push_back(STEP_IEXEC); plan.push_back(STEP_WBI); end
            6'b100011: begin plan.push_back(STEP_ADDR); plan.push_back(STEP_RD); plan.push_back(STEP_WBMEM); end
            6'b101011: begin plan.push_back(STEP_ADDR); plan.push_back(STEP_WR); end
            6'b000100, 6'b000101: plan.push_back(STEP_BR);
            6'b000010: plan.push_back(STEP_JMP);
            default: ;
        endcase
    endtask

    task automatic advance(input logic rdy);
        int step = currentStep();
        if (isMemStep(step)) begin
            if (rdy) begin
                waited = 0;
                if (step == STEP_FETCH) begin
                    curOp = nextOp;
                    buildPlan(curOp);
                end else begin
                    void'(plan.pop_front());
                end
            end else if (waited == TIMEOUT - 1) begin
                waited = 0;
                plan.delete();
            end else begin
                waited++;
            end
        end else begin
            void'(plan.pop_front());
        end
    endtask

    function automatic logic [16:0] expectOut(input int step, input logic [5:0] op, input logic z,
                                              input logic rdy, input int w);
        logic pw = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rdst = 0, rw = 0;
        logic srcA = 0, illegal = 0, merr = 0;
        logic [1:0] srcB = 2'b00, aluOp = 2'b00, pcs = 2'b00;
        case (step)
            STEP_FETCH:  begin mr = 1; srcB = 2'b01; irw = rdy; pw = rdy; end
            STEP_DECODE: begin srcB = 2'b11; illegal = !isKnown(op); end
            STEP_ADDR:   begin srcA = 1; srcB = 2'b10; end
            STEP_RD:     begin mr = 1; iord = 1; end
            STEP_WBMEM:  begin rw = 1; m2r = 1; end
            STEP_WR:     begin mw = 1; iord = 1; end
            STEP_EXEC:   begin srcA = 1; aluOp = 2'b10; end
            STEP_WBR:    begin rw = 1; rdst = 1; end
            STEP_IEXEC:  begin srcA = 1; srcB = 2'b10; aluOp = (op == 6'b001100) ? 2'b11 : 2'b00; end
            STEP_WBI:    begin rw = 1; aluOp = (op == 6'b001100) ? 2'b11 : 2'b00; end
            STEP_BR:     begin srcA = 1; aluOp = 2'b01; pcs = 2'b01; pw = (op == 6'b000100) ? z : !z; end
            STEP_JMP:    begin pcs = 2'b10; pw = 1; end
            default: ;
        endcase
        if (isMemStep(step) && !rdy && w == TIMEOUT - 1) merr = 1;
        return {pw, iord, mr, mw, irw, m2r, rdst, rw, srcA, srcB, aluOp, pcs, illegal, merr};
    endfunction

    // One clock: drive inputs on the falling edge, compare shortly after, step the model.
    task automatic applyStimulus(input logic rdy, input logic z, input string tag);
        int step = currentStep();
        @(negedge clk);
        rst_n    = 1'b1;
        memReady = rdy;
        zero     = z;
        opCode   = (step == STEP_FETCH) ? 6'($urandom) : curOp;
        #1;
        checkOutput(tag, dutVec, expectOut(step, curOp, z, rdy, waited));
        advance(rdy);
    endtask

    task automatic resetDut(input string tag);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        memReady = 1'b1;
        #1;
        checkOutput(tag, dutVec, 17'h0);
        plan.delete();
        waited = 0;
    endtask

    initial begin
        rst_n = 1'b0; memReady = 1'b0; zero = 1'b0; opCode = 6'd0;
        resetDut("reset");

        nextOp = 6'b000000;
        applyStimulus(1, 0, "r_fetch");
        applyStimulus(1, 0, "r_decode");
        applyStimulus(1, 0, "r_exec");
        applyStimulus(1, 0, "r_aluwb");
        applyStimulus(1, 0, "r_refetch");

        nextOp = 6'b100011;
        applyStimulus(1, 0, "lw_fetch");
        applyStimulus(1, 0, "lw_decode");
        applyStimulus(1, 0, "lw_memadr");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, "lw_rd_wait");
        applyStimulus(1, 0, "lw_rd_done");
        applyStimulus(1, 0, "lw_memwb");

        nextOp = 6'b000100;
        applyStimulus(1, 1, "beq_fetch");
        applyStimulus(1, 1, "beq_decode");
        applyStimulus(1, 1, "beq_branch");
        nextOp = 6'b000101;
        applyStimulus(1, 1, "bne_fetch");
        applyStimulus(1, 1, "bne_decode");
        applyStimulus(1, 1, "bne_branch");

        nextOp = 6'b101011;
        applyStimulus(1, 0, "sw_fetch");
        applyStimulus(1, 0, "sw_decode");
        applyStimulus(1, 0, "sw_memadr");
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(0, 0, "sw_timeout");
        applyStimulus(0, 0, "sw_after_timeout");

        nextOp = 6'b000010;
        for (int i = 0; i < TIMEOUT - 2; i++) applyStimulus(0, 0, "fetch_wait");
        applyStimulus(1, 0, "fetch_last_chance");
        applyStimulus(1, 0, "j_decode");
        applyStimulus(1, 0, "j_jump");

        nextOp = 6'b111111;
        applyStimulus(1, 0, "ill_fetch");
        applyStimulus(1, 0, "ill_decode");
        applyStimulus(1, 0, "ill_refetch");

        nextOp = 6'b000000;
        applyStimulus(1, 0, "r2_decode");
        applyStimulus(1, 0, "r2_to_exec");
        resetDut("reset_in_exec");
        applyStimulus(1, 0, "post_reset_fetch");

        for (int i = 0; i < 1500; i++) begin
            if (currentStep() == STEP_FETCH) nextOp = pickOp();
            applyStimulus($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
